// File: rtl/riscv_run_seq.sv
// Run sequencer for the RISC-V core. It holds the core in reset, runs it with a
// watchdog, pauses it on debug and reports done, timeout and run-cycle count.
module riscv_run_seq #(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             riscv_ready_in,
    input  logic             riscv_debug_in,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic             core_resetb,
    output logic             core_ce,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_RUN      = 3'd2,
        S_PAUSE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);

    state_t             cur, nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [CNT_W:0]     cnt_p1;
    logic               to, to_nxt, wdog_hit;

    // One extra bit keeps the equality from matching after the count saturates.
    assign cnt_p1   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_inc  = (&cnt) ? cnt : cnt_p1[CNT_W-1:0];
    assign wdog_hit = (|timeout_cycles) && (cnt_p1 == {1'b0, timeout_cycles});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_IDLE;
            hold_cnt <= '0;
            cnt      <= '0;
            to       <= 1'b0;
        end else begin
            cur      <= nxt;
            hold_cnt <= hold_nxt;
            cnt      <= cnt_nxt;
            to       <= to_nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        hold_nxt = hold_cnt;
        cnt_nxt  = cnt;
        to_nxt   = to;
        case (cur)
            S_IDLE: begin
                if (start && !abort) begin
                    nxt      = S_RST_HOLD;
                    hold_nxt = HOLD_LOAD;
                    cnt_nxt  = '0;
                    to_nxt   = 1'b0;
                end
            end
            S_RST_HOLD: begin
                if (abort)               nxt = S_IDLE;
                else if (hold_cnt == '0) nxt = S_RUN;
                else                     hold_nxt = hold_cnt - 1'b1;
            end
            S_RUN: begin
                cnt_nxt = cnt_inc;
                if (abort) begin
                    nxt = S_IDLE;
                end else if (riscv_ready_in) begin
                    nxt    = S_DONE;
                    to_nxt = 1'b0;
                end else if (wdog_hit) begin
                    nxt    = S_DONE;
                    to_nxt = 1'b1;
                end else if (riscv_debug_in) begin
                    nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    nxt = S_IDLE;
                end else if (riscv_ready_in) begin
                    nxt    = S_DONE;
                    to_nxt = 1'b0;
                end else if (!riscv_debug_in) begin
                    nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (abort) begin
                    nxt = S_IDLE;
                end else if (start) begin
                    nxt      = S_RST_HOLD;
                    hold_nxt = HOLD_LOAD;
                    cnt_nxt  = '0;
                    to_nxt   = 1'b0;
                end
            end
            default: nxt = S_IDLE;
        endcase
        // Abort drops the flags but leaves the count readable.
        if (abort && cur != S_IDLE) to_nxt = 1'b0;
    end

    assign core_resetb = (cur == S_RUN) || (cur == S_PAUSE) || (cur == S_DONE);
    assign core_ce     = (cur == S_RUN);
    assign busy        = (cur == S_RST_HOLD) || (cur == S_RUN) || (cur == S_PAUSE);
    assign done        = (cur == S_DONE);
    assign timed_out   = to;
    assign cycle_count = cnt;
    assign state       = cur;

endmodule
